// File: rtl/cache_line_refill.sv
`default_nettype none
// ============================================================================
// cache_line_refill : miss handler, burst-refills one 16-word line, then
// commits the tag and returns the requested word.   Rev 1.0
// ============================================================================
module cache_line_refill #(
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int INDEX_W  = 8,
  parameter  int OFFSET_W = 4,
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                miss_valid,
  input  logic [ADDR_W-1:0]   miss_addr,
  output logic                miss_ready,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_req_ready,
  input  logic                mem_rdata_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                fill_we,
  output logic [INDEX_W-1:0]  fill_index,
  output logic [OFFSET_W-1:0] fill_offset,
  output logic [DATA_W-1:0]   fill_data,
  output logic                tag_we,
  output logic [TAG_W-1:0]    tag_value,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data
);

  localparam int LINE_LSB   = OFFSET_W + 2;
  localparam int INDEX_LSB  = LINE_LSB;
  localparam int TAG_LSB    = LINE_LSB + INDEX_W;

  localparam logic [2:0] C_IDLE   = 3'd0;
  localparam logic [2:0] C_REQ    = 3'd1;
  localparam logic [2:0] C_FILL   = 3'd2;
  localparam logic [2:0] C_COMMIT = 3'd3;
  localparam logic [2:0] C_RESP   = 3'd4;

  localparam logic [OFFSET_W-1:0] C_LAST_BEAT = '1;

  logic [2:0]          state_q, state_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [DATA_W-1:0]   crit_q, crit_d;

  logic                miss_ready_q, miss_ready_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;
  logic                fill_we_q, fill_we_d;
  logic [INDEX_W-1:0]  fill_index_q, fill_index_d;
  logic [OFFSET_W-1:0] fill_offset_q, fill_offset_d;
  logic [DATA_W-1:0]   fill_data_q, fill_data_d;
  logic                tag_we_q, tag_we_d;
  logic [TAG_W-1:0]    tag_value_q, tag_value_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;

  logic accept;
  logic beat;
  logic unused_addr_lsbs;

  assign accept           = (state_q == C_IDLE) && miss_valid;
  assign beat             = (state_q == C_FILL) && mem_rdata_valid;
  assign unused_addr_lsbs = ^miss_addr[1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= C_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:   if (miss_valid)                        state_d = C_REQ;
      C_REQ:    if (mem_req_ready)                     state_d = C_FILL;
      C_FILL:   if (mem_rdata_valid && cnt_q == C_LAST_BEAT) state_d = C_COMMIT;
      C_COMMIT:                                        state_d = C_RESP;
      C_RESP:                                          state_d = C_IDLE;
      default:                                         state_d = C_IDLE;
    endcase
  end

  // Miss context, beat counter and critical-word capture
  always_comb begin
    tag_d    = tag_q;
    index_d  = index_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;
    crit_d   = crit_q;
    if (accept) begin
      tag_d    = miss_addr[ADDR_W-1:TAG_LSB];
      index_d  = miss_addr[TAG_LSB-1:INDEX_LSB];
      offset_d = miss_addr[LINE_LSB-1:2];
    end
    if ((state_q == C_REQ) && mem_req_ready) begin
      cnt_d = '0;
    end else if (beat) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (beat && (cnt_q == offset_q)) begin
      crit_d = mem_rdata;
    end
  end

  // Output logic: every output is registered, so it is derived from the
  // next state and the current beat rather than from state_q.
  always_comb begin
    miss_ready_d    = (state_d == C_IDLE);
    mem_req_valid_d = (state_d == C_REQ);
    mem_req_addr_d  = mem_req_addr_q;
    fill_we_d       = beat;
    fill_index_d    = fill_index_q;
    fill_offset_d   = fill_offset_q;
    fill_data_d     = fill_data_q;
    tag_we_d        = (state_d == C_RESP);
    tag_value_d     = tag_value_q;
    resp_valid_d    = (state_d == C_RESP);
    resp_data_d     = resp_data_q;
    if (accept) begin
      mem_req_addr_d = {miss_addr[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
    end
    if (beat) begin
      fill_index_d  = index_q;
      fill_offset_d = cnt_q;
      fill_data_d   = mem_rdata;
    end
    if (state_d == C_RESP) begin
      tag_value_d = tag_q;
      resp_data_d = crit_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q           <= '0;
      tag_q           <= '0;
      index_q         <= '0;
      offset_q        <= '0;
      crit_q          <= '0;
      miss_ready_q    <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      fill_we_q       <= 1'b0;
      fill_index_q    <= '0;
      fill_offset_q   <= '0;
      fill_data_q     <= '0;
      tag_we_q        <= 1'b0;
      tag_value_q     <= '0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
    end else begin
      cnt_q           <= cnt_d;
      tag_q           <= tag_d;
      index_q         <= index_d;
      offset_q        <= offset_d;
      crit_q          <= crit_d;
      miss_ready_q    <= miss_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      fill_we_q       <= fill_we_d;
      fill_index_q    <= fill_index_d;
      fill_offset_q   <= fill_offset_d;
      fill_data_q     <= fill_data_d;
      tag_we_q        <= tag_we_d;
      tag_value_q     <= tag_value_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
    end
  end

  assign miss_ready    = miss_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign fill_we       = fill_we_q;
  assign fill_index    = fill_index_q;
  assign fill_offset   = fill_offset_q;
  assign fill_data     = fill_data_q;
  assign tag_we        = tag_we_q;
  assign tag_value     = tag_value_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_line_refill.sv
`default_nettype none
// ============================================================================
// tb_cache_line_refill : directed bench for the line-refill miss handler.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_cache_line_refill;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_valid = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        miss_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rdata_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        fill_we;
  logic [7:0]  fill_index;
  logic [3:0]  fill_offset;
  logic [31:0] fill_data;
  logic        tag_we;
  logic [17:0] tag_value;
  logic        resp_valid;
  logic [31:0] resp_data;

  always #5 clk = ~clk;

  cache_line_refill dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .miss_valid      (miss_valid),
    .miss_addr       (miss_addr),
    .miss_ready      (miss_ready),
    .mem_req_valid   (mem_req_valid),
    .mem_req_addr    (mem_req_addr),
    .mem_req_ready   (mem_req_ready),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .fill_we         (fill_we),
    .fill_index      (fill_index),
    .fill_offset     (fill_offset),
    .fill_data       (fill_data),
    .tag_we          (tag_we),
    .tag_value       (tag_value),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Cycle counter and event recorder; sampled 3ns after each rising edge.
  int          cyc = 0;
  int          nfill = 0, ntag = 0, nresp = 0;
  logic [3:0]  f_off [64];
  logic [31:0] f_dat [64];
  logic [7:0]  f_idx [64];
  int          f_cyc [64];
  int          tag_cyc = 0, resp_cyc = 0;
  logic [17:0] tag_val = '0;
  logic [31:0] resp_dat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #3;
    if (fill_we) begin
      f_off[nfill % 64] = fill_offset;
      f_dat[nfill % 64] = fill_data;
      f_idx[nfill % 64] = fill_index;
      f_cyc[nfill % 64] = cyc;
      nfill++;
    end
    if (tag_we) begin
      ntag++;
      tag_cyc = cyc;
      tag_val = tag_value;
    end
    if (resp_valid) begin
      nresp++;
      resp_cyc = cyc;
      resp_dat = resp_data;
    end
  end

  int a_cyc = 0;

  task automatic check_reset_outs(input string nm);
    check({nm, "_miss_ready"},  64'(miss_ready), 64'd1);
    check({nm, "_req_valid"},   64'(mem_req_valid), 64'd0);
    check({nm, "_req_addr"},    64'(mem_req_addr), 64'd0);
    check({nm, "_fill_we"},     64'(fill_we), 64'd0);
    check({nm, "_fill_index"},  64'(fill_index), 64'd0);
    check({nm, "_fill_offset"}, 64'(fill_offset), 64'd0);
    check({nm, "_fill_data"},   64'(fill_data), 64'd0);
    check({nm, "_tag_we"},      64'(tag_we), 64'd0);
    check({nm, "_tag_value"},   64'(tag_value), 64'd0);
    check({nm, "_resp_valid"},  64'(resp_valid), 64'd0);
    check({nm, "_resp_data"},   64'(resp_data), 64'd0);
  endtask

  // Present a miss for one cycle; returns at the falling edge after acceptance.
  task automatic issue(input logic [31:0] addr);
    @(negedge clk);
    miss_valid = 1'b1;
    miss_addr  = addr;
    @(posedge clk);
    #1 a_cyc = cyc;
    @(negedge clk);
    miss_valid = 1'b0;
    check("miss_ready_busy", 64'(miss_ready), 64'd0);
  endtask

  // Memory side: hold off the request, then return 16 beats dbase+k.
  // gap = idle cycles between beats; abort = beat count at which reset hits.
  task automatic serve(input logic [31:0] addr, input int req_wait, input int gap,
                       input logic [31:0] dbase, input int abort);
    int k;
    int slot;
    int w;
    logic [31:0] line;
    line = {addr[31:6], 6'b0};
    for (int i = 0; i < req_wait; i++) begin
      check("req_hold_valid", 64'(mem_req_valid), 64'd1);
      check("req_hold_addr",  64'(mem_req_addr), 64'(line));
      check("req_hold_nofill", 64'(fill_we), 64'd0);
      @(negedge clk);
    end
    check("req_valid", 64'(mem_req_valid), 64'd1);
    check("req_addr",  64'(mem_req_addr), 64'(line));
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("req_drop", 64'(mem_req_valid), 64'd0);
    k = 0;
    slot = 0;
    while (k < 16) begin
      if (k == abort) begin
        mem_rdata_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      mem_rdata_valid = ((slot % (gap + 1)) == 0);
      mem_rdata       = dbase + 32'(k);
      if (mem_rdata_valid) k++;
      slot++;
      @(negedge clk);
    end
    mem_rdata_valid = 1'b0;
    w = 0;
    while (!resp_valid && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("resp_seen", 64'(resp_valid), 64'd1);
  endtask

  task automatic check_line(input logic [31:0] addr, input logic [31:0] dbase,
                            input int n0, input int t0, input int r0, input bit exact);
    int last;
    check("fill_count", 64'(nfill - n0), 64'd16);
    for (int k = 0; k < 16; k++) begin
      check("fill_offset", 64'(f_off[(n0 + k) % 64]), 64'(k));
      check("fill_data",   64'(f_dat[(n0 + k) % 64]), 64'(dbase + 32'(k)));
      check("fill_index",  64'(f_idx[(n0 + k) % 64]), 64'(addr[13:6]));
    end
    last = (n0 + 15) % 64;
    check("tag_count",  64'(ntag - t0), 64'd1);
    check("resp_count", 64'(nresp - r0), 64'd1);
    check("tag_value",  64'(tag_val), 64'(addr[31:14]));
    check("resp_data",  64'(resp_dat), 64'(dbase + 32'(addr[5:2])));
    check("tag_with_resp", 64'(tag_cyc - resp_cyc), 64'd0);
    check("tag_after_last_fill", 64'(tag_cyc - f_cyc[last]), 64'd1);
    if (exact) begin
      check("first_fill_cyc", 64'(f_cyc[n0 % 64] - a_cyc), 64'd2);
      check("last_fill_cyc",  64'(f_cyc[last] - a_cyc), 64'd17);
      check("tag_cyc",        64'(tag_cyc - a_cyc), 64'd18);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, t0, r0;
    logic [31:0] a1, a2;

    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(miss_ready), 64'd1);

    // 1: back-to-back beats, exact latency
    n0 = nfill; t0 = ntag; r0 = nresp;
    issue(32'h0001_2348);
    serve(32'h0001_2348, 0, 0, 32'h0000_00A0, 16);
    check_line(32'h0001_2348, 32'h0000_00A0, n0, t0, r0, 1'b1);
    check("t1_req_addr", 64'(mem_req_addr), 64'h0001_2340);
    check("t1_tag", 64'(tag_val), 64'h4);
    check("t1_index", 64'(f_idx[n0 % 64]), 64'h8D);
    check("t1_resp", 64'(resp_dat), 64'hA2);
    @(negedge clk);
    check("t1_ready_again", 64'(miss_ready), 64'd1);

    // 2: request held off for 5 cycles
    n0 = nfill; t0 = ntag; r0 = nresp;
    issue(32'h1234_5678);
    serve(32'h1234_5678, 5, 0, 32'h0000_1000, 16);
    check_line(32'h1234_5678, 32'h0000_1000, n0, t0, r0, 1'b0);

    // 3: gapped beats 1,0,0,1,...
    n0 = nfill; t0 = ntag; r0 = nresp;
    issue(32'hDEAD_BEEC);
    serve(32'hDEAD_BEEC, 0, 2, 32'h0000_5500, 16);
    check_line(32'hDEAD_BEEC, 32'h0000_5500, n0, t0, r0, 1'b0);

    // 4: stray beats in IDLE, then offset 15 as the critical word
    repeat (2) @(negedge clk);
    n0 = nfill;
    mem_rdata_valid = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    repeat (3) @(negedge clk);
    mem_rdata_valid = 1'b0;
    @(negedge clk);
    check("idle_stray_nofill", 64'(nfill - n0), 64'd0);
    n0 = nfill; t0 = ntag; r0 = nresp;
    issue(32'h0000_07FC);
    serve(32'h0000_07FC, 0, 0, 32'h0000_7700, 16);
    check_line(32'h0000_07FC, 32'h0000_7700, n0, t0, r0, 1'b1);
    check("t4_resp_beat15", 64'(resp_dat), 64'h770F);

    // 5: reset after beat 7, then a normal miss
    @(negedge clk);
    t0 = ntag; r0 = nresp;
    issue(32'h0ABC_0040);
    serve(32'h0ABC_0040, 0, 0, 32'h0000_0300, 8);
    repeat (4) @(negedge clk);
    check("rst_no_tag", 64'(ntag - t0), 64'd0);
    check("rst_no_resp", 64'(nresp - r0), 64'd0);
    check("rst_ready", 64'(miss_ready), 64'd1);
    n0 = nfill; t0 = ntag; r0 = nresp;
    issue(32'h0ABC_0044);
    serve(32'h0ABC_0044, 0, 0, 32'h0000_0400, 16);
    check_line(32'h0ABC_0044, 32'h0000_0400, n0, t0, r0, 1'b1);

    // 6: miss_valid held high across two misses
    a1 = 32'h0040_1234;
    a2 = 32'h0080_5678;
    n0 = nfill; t0 = ntag; r0 = nresp;
    @(negedge clk);
    miss_valid = 1'b1;
    miss_addr  = a1;
    @(posedge clk);
    #1 a_cyc = cyc;
    @(negedge clk);
    miss_addr = a2;
    serve(a1, 0, 0, 32'h0000_9000, 16);
    check_line(a1, 32'h0000_9000, n0, t0, r0, 1'b1);
    check("hold_resp_noreq", 64'(mem_req_valid), 64'd0);
    @(negedge clk);
    check("hold_idle_ready", 64'(miss_ready), 64'd1);
    check("hold_idle_noreq", 64'(mem_req_valid), 64'd0);
    @(negedge clk);
    check("hold_second_req", 64'(mem_req_valid), 64'd1);
    check("hold_second_addr", 64'(mem_req_addr), 64'h0080_5640);
    check("hold_second_busy", 64'(miss_ready), 64'd0);
    check("hold_accept_cyc", 64'(cyc - a_cyc), 64'd20);
    a_cyc = cyc;
    miss_valid = 1'b0;
    n0 = nfill; t0 = ntag; r0 = nresp;
    serve(a2, 0, 0, 32'h0000_A000, 16);
    check_line(a2, 32'h0000_A000, n0, t0, r0, 1'b1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_line_refill.md
Name: cache_line_refill

Overview:
- Miss-handling stage directly downstream of the direct-mapped cache lookup.
- Accepts one missed word address, issues a line-aligned burst read to main memory and streams the 16 returned words into the cache data array.
- Commits the tag only after the full line is written.
- Returns the originally requested word to the requester.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width
INDEX_W, 8, cache index bits (256 lines)
OFFSET_W, 4, word-offset bits (16 words per line); TAG_W = ADDR_W-INDEX_W-OFFSET_W-2 = 18 (derived localparam, not overridable)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
miss_valid  in  1  miss request present
miss_addr  in  ADDR_W  missed byte address
miss_ready  out  1  high only in IDLE
mem_req_valid  out  1  burst read request
mem_req_addr  out  ADDR_W  line-aligned address: {tag,index,6'b0}
mem_req_ready  in  1  memory accepts request
mem_rdata_valid  in  1  read beat valid
mem_rdata  in  DATA_W  read beat data
fill_we  out  1  data-array write strobe
fill_index  out  INDEX_W  line being filled
fill_offset  out  OFFSET_W  word within line
fill_data  out  DATA_W  word written
tag_we  out  1  tag/valid write strobe
tag_value  out  TAG_W  tag written at fill_index
resp_valid  out  1  one-cycle pulse: requested word available
resp_data  out  DATA_W  requested word

Behaviour:
- Address split: tag = addr[31:14], index = addr[13:6], offset = addr[5:2]; addr[1:0] ignored.
- All outputs registered. Reset (async, rst_n=0): state IDLE, beat counter 0, and every output 0 except miss_ready=1.
- States:
  - IDLE: miss_ready=1. miss_valid at an edge latches tag/index/offset -> REQ.
  - REQ: mem_req_valid=1, mem_req_addr stable. Stays until mem_req_ready=1 -> FILL, beat counter=0. mem_req_valid deasserts the cycle after the handshake.
  - FILL: each edge with mem_rdata_valid=1 captures beat k (counter value). Next cycle: fill_we=1, fill_offset=k, fill_data=beat, fill_index=latched index. Counter increments by 1. Gaps in mem_rdata_valid are allowed; fill_we is low in gap cycles. Beat 15 -> COMMIT.
  - COMMIT: one cycle; fill_we=1 for word 15 -> RESP.
  - RESP: one cycle; tag_we=1, tag_value=latched tag, resp_valid=1, resp_data=critical word -> IDLE.
- Critical word: captured on the beat whose counter equals the latched offset; resp_data holds it until the next resp_valid.
- Words are always filled in order 0..15 (no wrap-around ordering). The counter is OFFSET_W bits; it never wraps inside a burst.
- Ordering guarantee: tag_we never precedes the fill_we of word 15. A partially filled line is never marked valid.
- Outside FILL, mem_rdata_valid is ignored (no fill_we, counter unchanged).
- miss_valid outside IDLE is ignored; miss_ready=0 there. Only one miss is outstanding at a time.
- Latency: miss accepted at edge A with mem_req_ready=1 and back-to-back beats:
  - mem_req_valid in cycle A+1
  - beats in A+2..A+17
  - fill_we in A+3..A+18
  - tag_we/resp_valid in A+19
  - miss_ready=1 again in A+20
- Reset mid-operation: immediate return to IDLE. No tag_we is issued. Any partially written data words remain but stay invalid because the tag is not written.
- Simultaneous miss_valid and RESP completion: the miss is not accepted until the IDLE cycle.

Test Plan:
1. Reset, miss_addr=0x0001_2348, mem_req_ready=1, 16 back-to-back beats data=0xA0+k -> mem_req_addr=0x0001_2340; fill_index=0x8D, offsets 0..15 in A+3..A+18; tag_we at A+19 with tag_value=0x00004; resp_data=0xA2.
2. mem_req_ready held low 5 cycles -> mem_req_valid stays high, address stable; no fill_we until beats arrive.
3. Beats with mem_rdata_valid gaps (pattern 1,0,0,1,...) -> exactly 16 fill_we pulses, contiguous offsets, tag_we exactly once, after the last fill.
4. miss_addr offset=15 (addr[5:2]=4'hF) -> resp_data equals beat 15; stray mem_rdata_valid in IDLE produces no fill_we.
5. rst_n low after beat 7 -> all outputs reset asynchronously, miss_ready=1, tag_we never pulses; a new miss afterwards completes normally.
6. miss_valid held high continuously across two misses -> second accepted only at A+20; mem_req_addr updates to the new line.
